// File: rtl/pc_seq_if.sv
// Sequencer bus: control from the decoder (stall/op_kind/flags/target) and PC/stack status back.
// Signal names are shared with the pc_seq block; master drives control, slave drives status.
interface pc_seq_if #(
    parameter int PC_W      = 8,
    parameter int RAS_DEPTH = 4
);
    logic                       stall;
    logic [2:0]                 op_kind;
    logic                       z;
    logic                       lt;
    logic [PC_W-1:0]            target;
    logic [PC_W-1:0]            PC;
    logic                       done;
    logic [$clog2(RAS_DEPTH):0] ras_cnt;
    logic                       ras_err;

    modport master (
        output stall, op_kind, z, lt, target,
        input  PC, done, ras_cnt, ras_err
    );

    modport slave (
        input  stall, op_kind, z, lt, target,
        output PC, done, ras_cnt, ras_err
    );
endinterface

// File: rtl/pc_seq.sv
// Program-counter sequencer with RUN/HALTED FSM and an optional circular return-address stack.
// Define PC_SEQ_RAS_EN to build the stack; otherwise CALL acts as JUMP and RET as NEXT.
module pc_seq #(
    parameter int PC_W       = 8,
    parameter int RAS_DEPTH  = 4,
    parameter int START_ADDR = 0
) (
    input  logic     clk,
    input  logic     reset,
    pc_seq_if.slave  bus
);

    localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

    typedef enum logic [2:0] {
        OP_NEXT  = 3'd0,
        OP_JUMP  = 3'd1,
        OP_BR_Z  = 3'd2,
        OP_BR_LT = 3'd3,
        OP_CALL  = 3'd4,
        OP_RET   = 3'd5,
        OP_HALT  = 3'd6,
        OP_RSVD  = 3'd7
    } op_e;

    typedef enum logic {
        S_RUN    = 1'b0,
        S_HALTED = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pc_plus1;
    op_e             op;
    logic            advance;
    logic            ras_hit;
    logic [PC_W-1:0] ras_top;

    assign op       = op_e'(bus.op_kind);
    assign pc_plus1 = pc_q + PC_W'(1);
    assign advance  = (state_q == S_RUN) && !bus.stall;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RUN;
            pc_q    <= PC_W'(START_ADDR);
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // NOTE: defaulting every comb output first keeps the block free of inferred latches.
    always_comb begin
        state_d = state_q;
        if (advance && op == OP_HALT) begin
            state_d = S_HALTED;
        end
    end

    // Offsets are the same width as PC, so plain addition is sign-extension plus modulo wrap.
    always_comb begin
        pc_d = pc_q;
        if (advance) begin
            case (op)
                OP_JUMP,
                OP_CALL:  pc_d = bus.target;
                OP_BR_Z:  pc_d = bus.z  ? pc_q + bus.target : pc_plus1;
                OP_BR_LT: pc_d = bus.lt ? pc_q + bus.target : pc_plus1;
                OP_RET:   pc_d = ras_hit ? ras_top : pc_plus1;
                OP_HALT:  pc_d = pc_q;
                default:  pc_d = pc_plus1;
            endcase
        end
    end

    always_comb begin
        bus.PC   = pc_q;
        bus.done = (state_q == S_HALTED);
    end

`ifdef PC_SEQ_RAS_EN
    localparam int SP_W = $clog2(RAS_DEPTH);

    logic [PC_W-1:0]  ras_q [RAS_DEPTH];
    logic [SP_W-1:0]  sp_q, sp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             push, pop, full, empty;

    // sp_q is the next write slot; a push when full overwrites the oldest entry by wrapping.
    always_comb begin
        push    = advance && (op == OP_CALL);
        pop     = advance && (op == OP_RET);
        full    = (cnt_q == CNT_W'(RAS_DEPTH));
        empty   = (cnt_q == '0);
        ras_hit = !empty;
        ras_top = ras_q[sp_q - SP_W'(1)];
        sp_d    = sp_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        if (push) begin
            sp_d = sp_q + SP_W'(1);
            if (full) begin
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (pop) begin
            if (empty) begin
                err_d = 1'b1;
            end else begin
                sp_d  = sp_q - SP_W'(1);
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sp_q  <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // NOTE: stack storage is deliberately not reset; its contents are only read when ras_cnt covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            ras_q[sp_q] <= pc_plus1;
        end
    end

    assign bus.ras_cnt = cnt_q;
    assign bus.ras_err = err_q;
`else
    assign ras_hit     = 1'b0;
    assign ras_top     = '0;
    assign bus.ras_cnt = CNT_W'(0);
    assign bus.ras_err = 1'b0;
`endif

endmodule
